apb_master: RTL
===============

# apb_master

APB requester that drives the `apb_slave` port set (`PADDR`/`PWRITE`/`PSELx`/`PENABLE`/`PWDATA`) from a simple valid/ready command interface, then returns read data and status on a one-cycle response strobe. It is the initiating end of the team's APB link, sits between a test/stimulus or CPU-side agent and one APB slave, and bounds slave wait states with a timeout.

## Interface
- `addrWidth`, 8, APB address width.
- `dataWidth`, 32, APB data width.
- `maxWait`, 16, maximum ACCESS cycles with `PREADY`=0 before abort; 0 disables the timeout.
- `PCLK`  in  1  clock; all state changes on the rising edge.
- `PRESENTn`  in  1  reset; asynchronous assert, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when `cmd_valid` and `cmd_ready` are both high.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  addrWidth  transfer address.
- `cmd_wdata`  in  dataWidth  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle completion strobe.
- `rsp_rdata`  out  dataWidth  read data; 0 for writes and for aborted transfers.
- `rsp_err`  out  1  `PSLVERR` sampled at completion, or timeout.
- `rsp_timeout`  out  1  transfer aborted by the wait limit.
- `PADDR`  out  addrWidth  APB address.
- `PWRITE`  out  1  APB direction.
- `PSELx`  out  1  APB select.
- `PENABLE`  out  1  APB enable.
- `PWDATA`  out  dataWidth  APB write data.
- `PRDATA`  in  dataWidth  slave read data.
- `PREADY`  in  1  slave ready; tie to 1 for zero-wait slaves.
- `PSLVERR`  in  1  slave error; tie to 0 if unused.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE:**
  - `cmd_ready`=1.
  - On handshake, register `cmd_addr`/`cmd_write`/`cmd_wdata` into `PADDR`/`PWRITE`/`PWDATA`, then go to SETUP.
- **SETUP:**
  - `PSELx`=1, `PENABLE`=0, `cmd_ready`=0.
  - Always go to ACCESS after one cycle.
- **ACCESS:**
  - `PSELx`=1, `PENABLE`=1.
  - If `PREADY`=1, the transfer completes: capture `PRDATA` (reads only) and `PSLVERR`, then go to IDLE.
  - If `PREADY`=0, stay in ACCESS and increment the wait counter.
- **Address/control stability:** `PADDR`, `PWRITE` and `PWDATA` hold from SETUP until the cycle after completion. They keep their last value in IDLE; no requirement to zero them.
- **Timeout:**
  - Condition: `maxWait`>0, in ACCESS, and the wait counter reaches `maxWait` with `PREADY` still 0.
  - Action: abort and go to IDLE. Response is `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - If `PREADY`=1 in the same cycle the limit is reached, `PREADY` wins and the transfer completes normally.
- **Wait counter:** width `$clog2(maxWait+1)`, minimum 1 bit. Clears on entry to SETUP and saturates; it never wraps.
- **Response:** `rsp_valid` pulses for exactly one cycle, the cycle after completion or abort. `rsp_*` fields hold until the next strobe.
- **Reset (`PRESENTn`=0, asynchronous):**
  - State goes to IDLE.
  - `PSELx`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `rsp_timeout` all go to 0.
  - `cmd_ready` is 0 while reset is asserted and 1 from the first edge after release.
  - Reset in the middle of a transfer drops `PSELx`/`PENABLE` immediately and produces no response.

## Timing
- Zero-wait transfer: handshake at edge N, SETUP in cycle N+1, ACCESS in N+2, `rsp_valid` in N+3, `cmd_ready` high again in N+3.
- Each slave wait state adds one ACCESS cycle.
- Minimum spacing between handshakes is 3 cycles. `PSELx` drops for at least one IDLE cycle between transfers; there is no back-to-back SETUP.
- `cmd_ready` is a pure function of state. There is no combinational path from `cmd_valid` or `PREADY` to any output.

## Structure
- Shared package `apb_pkg`:
  - `apb_state_t` enum (IDLE, SETUP, ACCESS).
  - APB default width constants (`APB_ADDR_W`=8, `APB_DATA_W`=32).
  - The response-record typedef, also used by the slave-side bench.
- Single module. The wait counter is inline; no sub-module is warranted.
- A top wrapper `apb_master_slave_tb` instantiates `apb_master` plus `apb_slave`, with `PREADY` tied to 1 and `PSLVERR` tied to 0, and dumps `dump_apb_master.vcd`.

## Test plan
- **Write then read back:** write 0xDEADBEEF to 0x10, then read 0x10 against `apb_slave` → `rsp_rdata`=0xDEADBEEF, `rsp_err`=0; each transfer takes 3 cycles from handshake to `rsp_valid`.
- **Wait states:** `PREADY` low for 5 ACCESS cycles with `maxWait`=16 → `PENABLE` high for 6 cycles, `PADDR` stable throughout, `rsp_valid` one cycle after `PREADY` rises.
- **Timeout:**
  - `maxWait`=4 and `PREADY` held 0 → abort after 4 wait cycles, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0, `PSELx` low the next cycle.
  - Variant with `PREADY`=1 exactly on the 4th cycle → normal completion, `rsp_timeout`=0.
- **Slave error:** read 0x20 with `PSLVERR`=1 at completion → `rsp_err`=1, `rsp_timeout`=0.
- **Command held across a busy window:** `cmd_valid` held high for 10 cycles with changing addresses → only the commands present when `cmd_ready`=1 are issued; `PSELx` is low for ≥1 cycle between transfers.
- **Reset mid-transfer:** assert `PRESENTn`=0 during ACCESS → `PSELx`/`PENABLE` go to 0 without waiting for an edge and no `rsp_valid` appears; after release, a read of 0x00 completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: definitions shared by the APB master and the slave-side benches.
//   apb_state_t   - transfer phase (idle, setup, access)
//   APB_ADDR_W    - default APB address width
//   APB_DATA_W    - default APB data width
//   apb_rsp_t     - completion record: read data, error and timeout flags
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } apb_state_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage : apb_pkg

// File: rtl/apb_master.sv
// apb_master: APB requester driven by a valid/ready command port.
//   PCLK, PRESENTn          - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     - command handshake; cmd_write/cmd_addr/cmd_wdata describe it
//   rsp_valid               - one-cycle completion strobe; rsp_rdata/rsp_err/rsp_timeout
//                             hold until the next strobe
//   PADDR/PWRITE/PSELx/PENABLE/PWDATA - APB request outputs (all registered)
//   PRDATA/PREADY/PSLVERR   - APB slave returns
// ACCESS cycles with PREADY low are bounded by maxWait (0 disables the limit).
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned addrWidth = APB_ADDR_W,
    parameter int unsigned dataWidth = APB_DATA_W,
    parameter int unsigned maxWait   = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESENTn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic [addrWidth-1:0] PADDR,
    output logic                 PWRITE,
    output logic                 PSELx,
    output logic                 PENABLE,
    output logic [dataWidth-1:0] PWDATA,
    input  logic [dataWidth-1:0] PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    localparam int unsigned WaitW = (maxWait > 0) ? $clog2(maxWait + 1) : 1;
    // Counter value seen during the last permitted wait cycle; abort happens on that edge.
    localparam logic [WaitW-1:0] WaitLast = WaitW'((maxWait > 0) ? maxWait - 1 : 0);

    apb_state_t           state_q;
    logic                 cmd_ready_q;
    logic                 psel_q;
    logic                 penable_q;
    logic                 pwrite_q;
    logic [addrWidth-1:0] paddr_q;
    logic [dataWidth-1:0] pwdata_q;
    logic                 rsp_valid_q;
    logic [dataWidth-1:0] rsp_rdata_q;
    logic                 rsp_err_q;
    logic                 rsp_timeout_q;
    logic [WaitW-1:0]     wait_q;

    logic wait_limit;
    assign wait_limit = (maxWait > 0) && (wait_q == WaitLast);

    always_ff @(posedge PCLK or negedge PRESENTn) begin
        if (!PRESENTn) begin
            state_q       <= StIdle;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_q        <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // cmd_ready_q stays low for the first cycle out of reset.
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        paddr_q     <= cmd_addr;
                        pwrite_q    <= cmd_write;
                        pwdata_q    <= cmd_wdata;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        wait_q      <= '0;
                        state_q     <= StSetup;
                    end
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    if (PREADY || wait_limit) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        cmd_ready_q   <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StIdle;
                        // PREADY takes priority over a timeout reached on the same edge.
                        rsp_rdata_q   <= (PREADY && !pwrite_q) ? PRDATA : '0;
                        rsp_err_q     <= PREADY ? PSLVERR : 1'b1;
                        rsp_timeout_q <= !PREADY;
                    end else if (wait_q != '1) begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule : apb_master
